// File: rtl/imm_field_decode_if.sv
// Stream bundle between fetch, the immediate field decoder and the sign-extension stage.
// slave is the decoder's view; master is the fetch/extender (or bench) view.
interface imm_field_decode_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm_raw;
   logic [5:0]      out_sign_pos;
   logic            out_ext_en;
   logic [2:0]      out_fmt;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_imm_raw,
             out_sign_pos, out_ext_en, out_fmt, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_imm_raw,
             out_sign_pos, out_ext_en, out_fmt, out_illegal
   );
endinterface

// File: rtl/imm_field_decode.sv
// RV32I immediate field extractor: right-justified raw immediate, field width and extend enable per format.
// Define IMM_DECODE_SKID_EN for a two-entry skid buffer with registered in_ready; otherwise single stage.
module imm_field_decode #(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   imm_field_decode_if.slave   bus
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_SH  = 3'd6,
      FMT_BAD = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm_raw;
      logic [5:0]      sign_pos;
      logic            ext_en;
      fmt_e            fmt;
      logic            illegal;
   } entry_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   entry_t          dec;
   entry_t          main_q;
   logic            main_valid_q;
   logic            accept;
   logic            drain;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] ins;

   assign ins    = bus.in_instr;
   assign opcode = ins[6:0];
   assign funct3 = ins[14:12];

   // Unknown opcodes fall through as BAD entries instead of stalling the pipe.
   always_comb begin
      dec          = '0;
      dec.instr    = bus.in_instr;
      dec.pc       = bus.in_pc;
      dec.fmt      = FMT_BAD;
      dec.illegal  = 1'b1;
      case (opcode)
         OPC_OP_IMM: begin
            dec.illegal = 1'b0;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.fmt      = FMT_SH;
               dec.imm_raw  = {{(XLEN-5){1'b0}}, ins[24:20]};
               dec.sign_pos = 6'd5;
               dec.ext_en   = 1'b0;
            end else begin
               dec.fmt      = FMT_I;
               dec.imm_raw  = {{(XLEN-12){1'b0}}, ins[31:20]};
               dec.sign_pos = 6'd12;
               dec.ext_en   = 1'b1;
            end
         end
         OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
            dec.illegal  = 1'b0;
            dec.fmt      = FMT_I;
            dec.imm_raw  = {{(XLEN-12){1'b0}}, ins[31:20]};
            dec.sign_pos = 6'd12;
            dec.ext_en   = 1'b1;
         end
         OPC_STORE: begin
            dec.illegal  = 1'b0;
            dec.fmt      = FMT_S;
            dec.imm_raw  = {{(XLEN-12){1'b0}}, ins[31:25], ins[11:7]};
            dec.sign_pos = 6'd12;
            dec.ext_en   = 1'b1;
         end
         OPC_BRANCH: begin
            dec.illegal  = 1'b0;
            dec.fmt      = FMT_B;
            dec.imm_raw  = {{(XLEN-13){1'b0}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            dec.sign_pos = 6'd13;
            dec.ext_en   = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.illegal  = 1'b0;
            dec.fmt      = FMT_U;
            dec.imm_raw  = {ins[31:12], 12'h000};
            dec.sign_pos = 6'd32;
            dec.ext_en   = 1'b0;
         end
         OPC_JAL: begin
            dec.illegal  = 1'b0;
            dec.fmt      = FMT_J;
            dec.imm_raw  = {{(XLEN-21){1'b0}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            dec.sign_pos = 6'd21;
            dec.ext_en   = 1'b1;
         end
         OPC_OP: begin
            dec.illegal = 1'b0;
            dec.fmt     = FMT_R;
         end
         default: ;
      endcase
   end

   assign accept = bus.in_valid && bus.in_ready;
   assign drain  = main_valid_q && bus.out_ready;

`ifdef IMM_DECODE_SKID_EN
   entry_t skid_q;
   logic   skid_valid_q;

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
   assign bus.in_ready = !reset && !flush && !skid_valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else if (flush) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (skid_valid_q) begin
         if (drain) begin
            main_q       <= skid_q;
            skid_valid_q <= 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q || drain) begin
            main_q       <= dec;
            main_valid_q <= 1'b1;
         end else begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
         end
      end else if (drain) begin
         main_valid_q <= 1'b0;
      end
   end
`else
   assign bus.in_ready = !reset && !flush && (!main_valid_q || bus.out_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
      end else if (flush) begin
         main_valid_q <= 1'b0;
      end else if (accept) begin
         main_q       <= dec;
         main_valid_q <= 1'b1;
      end else if (drain) begin
         main_valid_q <= 1'b0;
      end
   end
`endif

   assign bus.out_valid    = main_valid_q;
   assign bus.out_instr    = main_q.instr;
   assign bus.out_pc       = main_q.pc;
   assign bus.out_imm_raw  = main_q.imm_raw;
   assign bus.out_sign_pos = main_q.sign_pos;
   assign bus.out_ext_en   = main_q.ext_en;
   assign bus.out_fmt      = main_q.fmt;
   assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_field_decode.sv
// Directed bench for imm_field_decode: decode vector table, stall/order, flush and async reset sequences.
// Expected in_ready under stall follows the build (IMM_DECODE_SKID_EN gives two entries of storage).
module tb_imm_field_decode;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   imm_field_decode_if #(.XLEN(32)) bus ();

   imm_field_decode #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef IMM_DECODE_SKID_EN
   localparam int CAP  = 2;
   localparam bit SKID = 1'b1;
`else
   localparam int CAP  = 1;
   localparam bit SKID = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [31:0] raw;
      logic [5:0]  pos;
      logic        ext;
      logic        ill;
   } vec_t;

   vec_t vecs[14];
   int   vec_count   = 0;
   int   miscompares = 0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic check_entry(input string tag, input vec_t v, input logic [31:0] pc);
      check_output({tag, ".valid"},    {31'd0, bus.out_valid}, 32'd1);
      check_output({tag, ".fmt"},      {29'd0, bus.out_fmt}, {29'd0, v.fmt});
      check_output({tag, ".raw"},      bus.out_imm_raw, v.raw);
      check_output({tag, ".sign_pos"}, {26'd0, bus.out_sign_pos}, {26'd0, v.pos});
      check_output({tag, ".ext_en"},   {31'd0, bus.out_ext_en}, {31'd0, v.ext});
      check_output({tag, ".illegal"},  {31'd0, bus.out_illegal}, {31'd0, v.ill});
      check_output({tag, ".instr"},    bus.out_instr, v.instr);
      check_output({tag, ".pc"},       bus.out_pc, pc);
   endtask

   task automatic apply_stimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = valid;
      bus.in_instr = instr;
      bus.in_pc    = pc;
   endtask

   initial begin
      vec_t        s [4];
      int          cnt, sent, drained;
      logic        prev_stalled, acc, drn;
      logic [31:0] prev_instr, prev_pc, prev_raw;

      reset = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      apply_stimulus(1'b0, 32'd0, 32'd0);

      vecs[0]  = '{32'hFFF00093, 3'd1, 32'h00000FFF, 6'd12, 1'b1, 1'b0};
      vecs[1]  = '{32'hFE112E23, 3'd2, 32'h00000FFC, 6'd12, 1'b1, 1'b0};
      vecs[2]  = '{32'h123450B7, 3'd4, 32'h12345000, 6'd32, 1'b0, 1'b0};
      vecs[3]  = '{32'h0000007F, 3'd7, 32'h00000000, 6'd0,  1'b0, 1'b1};
      vecs[4]  = '{32'h002080B3, 3'd0, 32'h00000000, 6'd0,  1'b0, 1'b0};
      vecs[5]  = '{32'hFE000EE3, 3'd3, 32'h00001FFC, 6'd13, 1'b1, 1'b0};
      vecs[6]  = '{32'hFFDFF06F, 3'd5, 32'h001FFFFC, 6'd21, 1'b1, 1'b0};
      vecs[7]  = '{32'h00309093, 3'd6, 32'h00000003, 6'd5,  1'b0, 1'b0};
      vecs[8]  = '{32'h40515093, 3'd6, 32'h00000005, 6'd5,  1'b0, 1'b0};
      vecs[9]  = '{32'h00412083, 3'd1, 32'h00000004, 6'd12, 1'b1, 1'b0};
      vecs[10] = '{32'h00001117, 3'd4, 32'h00001000, 6'd32, 1'b0, 1'b0};
      vecs[11] = '{32'h000080E7, 3'd1, 32'h00000000, 6'd12, 1'b1, 1'b0};
      vecs[12] = '{32'h00000073, 3'd1, 32'h00000000, 6'd12, 1'b1, 1'b0};
      vecs[13] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 6'd0,  1'b0, 1'b1};

      repeat (2) @(negedge clk);
      #1;
      check_output("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_output("reset.in_ready",  {31'd0, bus.in_ready}, 32'd0);
      check_output("reset.imm_raw",   bus.out_imm_raw, 32'd0);
      check_output("reset.instr",     bus.out_instr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("release.in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Back-to-back table run: each entry must appear exactly one edge after acceptance.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         apply_stimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4));
         #1;
         check_output($sformatf("tbl%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
         @(posedge clk);
         #1;
         check_entry($sformatf("tbl%0d", i), vecs[i], 32'h1000 + 32'(i * 4));
      end
      @(negedge clk);
      apply_stimulus(1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check_output("tbl_end.out_valid", {31'd0, bus.out_valid}, 32'd0);

      // Stall for three cycles, then drain; order, stability and ready are checked against an occupancy model.
      s[0] = vecs[0]; s[1] = vecs[1]; s[2] = vecs[2]; s[3] = vecs[7];
      cnt = 0; sent = 0; drained = 0; prev_stalled = 1'b0;
      prev_instr = 0; prev_pc = 0; prev_raw = 0;
      for (int c = 0; c < 30 && drained < 4; c++) begin
         @(negedge clk);
         bus.out_ready = (c >= 3);
         if (sent < 4) apply_stimulus(1'b1, s[sent].instr, 32'h2000 + 32'(sent * 4));
         else          apply_stimulus(1'b0, 32'd0, 32'd0);
         #1;
         check_output($sformatf("stall%0d.in_ready", c), {31'd0, bus.in_ready},
                      {31'd0, (cnt < CAP) || (!SKID && bus.out_ready)});
         check_output($sformatf("stall%0d.out_valid", c), {31'd0, bus.out_valid}, {31'd0, cnt > 0});
         if (prev_stalled) begin
            check_output($sformatf("stall%0d.hold_instr", c), bus.out_instr, prev_instr);
            check_output($sformatf("stall%0d.hold_pc", c), bus.out_pc, prev_pc);
            check_output($sformatf("stall%0d.hold_raw", c), bus.out_imm_raw, prev_raw);
         end
         drn = bus.out_valid && bus.out_ready;
         acc = bus.in_valid && bus.in_ready;
         if (drn && drained < 4) begin
            check_entry($sformatf("stream%0d", drained), s[drained], 32'h2000 + 32'(drained * 4));
            drained++;
         end
         prev_stalled = bus.out_valid && !bus.out_ready;
         prev_instr = bus.out_instr; prev_pc = bus.out_pc; prev_raw = bus.out_imm_raw;
         cnt  = cnt + int'(acc) - int'(drn);
         sent = sent + int'(acc);
         @(posedge clk);
      end
      check_output("stream.drained", 32'(drained), 32'd4);
      @(negedge clk);
      apply_stimulus(1'b0, 32'd0, 32'd0);
      #1;
      check_output("stream.no_dup", {31'd0, bus.out_valid}, 32'd0);

      // Flush with buffered entries and a pending input.
      bus.out_ready = 1'b0;
      apply_stimulus(1'b1, vecs[0].instr, 32'h3000);
      @(negedge clk);
      apply_stimulus(1'b1, vecs[1].instr, 32'h3004);
      @(negedge clk);
      flush = 1'b1;
      apply_stimulus(1'b1, vecs[2].instr, 32'h3008);
      #1;
      check_output("flush.in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check_output("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      bus.out_ready = 1'b1;
      apply_stimulus(1'b1, vecs[6].instr, 32'h300C);
      #1;
      check_output("post_flush.in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_entry("post_flush", vecs[6], 32'h300C);
      @(negedge clk);
      apply_stimulus(1'b0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check_output("post_flush.empty", {31'd0, bus.out_valid}, 32'd0);

      // Asynchronous reset in the middle of a cycle with an entry buffered.
      @(negedge clk);
      bus.out_ready = 1'b0;
      apply_stimulus(1'b1, vecs[0].instr, 32'h4000);
      @(posedge clk);
      #2;
      check_output("pre_reset.out_valid", {31'd0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check_output("async_reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_output("async_reset.instr",     bus.out_instr, 32'd0);
      check_output("async_reset.raw",       bus.out_imm_raw, 32'd0);
      check_output("async_reset.sign_pos",  {26'd0, bus.out_sign_pos}, 32'd0);
      check_output("async_reset.in_ready",  {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      apply_stimulus(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      apply_stimulus(1'b1, vecs[7].instr, 32'h5000);
      #1;
      check_output("after_reset.in_ready",  {31'd0, bus.in_ready}, 32'd1);
      check_output("after_reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check_entry("after_reset.slli", vecs[7], 32'h5000);
      @(negedge clk);
      apply_stimulus(1'b0, 32'd0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/imm_field_decode.md
# imm_field_decode

Decode-stage block that accepts fetched RV32I instruction words and extracts the raw immediate field for each format. It feeds the downstream sign-extension stage with the right-justified raw immediate, the field width that locates the sign bit, and an extend enable. The block sits between fetch and the immediate extender. It is fully pipelined with valid/ready handshakes on both sides and a flush input for branch redirects.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  drops all buffered instructions at the next edge.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  32  instruction address.
- out_valid  output  1  decoded entry is presented.
- out_ready  input  1  downstream accepts the entry.
- out_instr  output  32  registered copy of the instruction.
- out_pc  output  32  registered copy of the PC.
- out_imm_raw  output  32  right-justified raw immediate; upper bits are zero.
- out_sign_pos  output  6  immediate field width, i.e. sign bit index + 1.
- out_ext_en  output  1  downstream must sign-extend.
- out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, BAD=7.
- out_illegal  output  1  the opcode is not a supported RV32I opcode.

## Operation
- Handshake:
  - A transfer occurs on an edge where valid and ready are both high.
  - out_* must hold stable while out_valid=1 and out_ready=0.
- Format selection by opcode[6:0]:
  - 0010011 (OP-IMM) with funct3=001 or 101 → SH: raw = instr[24:20], width 5, ext_en 0.
  - Other 0010011, plus 0000011, 1100111, 1110011 → I: raw = instr[31:20], width 12, ext_en 1.
  - 0100011 → S: raw = {instr[31:25], instr[11:7]}, width 12, ext_en 1.
  - 1100011 → B: raw = {instr[31], instr[7], instr[30:25], instr[11:8], 0}, width 13, ext_en 1.
  - 0110111, 0010111 → U: raw = {instr[31:12], 12'h000}, width 32, ext_en 0.
  - 1101111 → J: raw = {instr[31], instr[19:12], instr[20], instr[30:21], 0}, width 21, ext_en 1.
  - 0110011 → R: raw 0, width 0, ext_en 0.
  - Any other opcode → BAD: raw 0, width 0, ext_en 0, illegal 1. The entry still flows; the block does not stall on it.
- Decode is combinational on in_instr. The result is registered together with pc and instr.
- Flush:
  - flush has priority over all other activity. All entries are invalidated at the edge.
  - in_ready is forced to 0 while flush=1, so no input is accepted in a flush cycle.
  - A downstream handshake completing in the same cycle is discarded.
- Reset:
  - out_valid=0 and all out_* data=0.
  - in_ready=0 while reset is asserted and 1 on the first cycle after release.
  - Reset mid-transfer discards all buffered entries.

## Timing
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one instruction per cycle with out_ready held high.
- With skid (see Configuration):
  - Storage is a main register plus one skid register. in_ready = !skid_valid, registered.
  - If main is full, out_ready=0, and input is accepted, the input goes to skid and in_ready drops on the next cycle.
  - When out_ready=1 with skid full, skid moves to main at the edge, and in_ready returns to 1 in the following cycle.
  - A simultaneous accept and drain while skid is empty must not lose or duplicate entries.
- Without skid:
  - Single register. in_ready = !out_valid || out_ready, combinational.
- Order is strictly preserved in all cases.

## Configuration
- IMM_DECODE_SKID_EN:
  - Defined: two-entry skid buffer with registered in_ready; no combinational ready path from out_ready to in_ready.
  - Undefined: single stage with combinational in_ready.
- Latency and decode results are identical in both builds.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1:
  - Next cycle: fmt=1, out_imm_raw=0x00000FFF, sign_pos=12, ext_en=1, illegal=0.
- SW x1,-4(x2) (0xFE112E23) followed by LUI x1,0x12345 (0x123450B7) back-to-back:
  - First entry: S, raw 0x00000FFC, sign_pos=12.
  - Second entry: U, raw 0x12345000, sign_pos=32, ext_en=0.
  - Both appear on consecutive cycles.
- Stream of 4 instructions with out_ready held 0 for 3 cycles:
  - Outputs stay stable while stalled. in_ready drops after two entries are buffered (skid build).
  - All 4 emerge in order with no loss or duplication.
- 0x0000007F:
  - fmt=7, illegal=1, raw=0, ext_en=0.
  - The following instruction flows normally.
- flush asserted with two entries buffered and in_valid=1:
  - out_valid=0 after the edge; the input is not accepted (in_ready=0).
  - Next instruction latency is 1 cycle.
- reset asserted asynchronously mid-stream:
  - out_valid drops immediately and outputs read 0.
  - After release, in_ready=1 and a SLLI x1,x1,3 (0x00309093) yields fmt=6, raw=3, sign_pos=5, ext_en=0.
